diffaddmul_sched: RTL
=====================

# diffaddmul_sched

- Sequencing controller for the difference/add/multiply datapath.
- Accepts operand sets `(i, j, k, op)` from two requesters through valid/ready handshakes, with round-robin arbitration.
- Computes `|i−j|`, then either adds `k` in one step or multiplies by `k` over several steps using 4×4 partial products with zero-skip.
- Returns the 8-bit result with the requester ID over a valid/ready output port. One transaction is in flight at a time.

## Interface
Parameters: none (all widths are fixed at 8 bits).

Ports:
- `clk`  in  1  clock; reset `rst`, synchronous, active-high; clock `clk`.
- `rst`  in  1  synchronous active-high reset.
- `req0_valid`  in  1  requester 0 has a transaction.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_i`, `req0_j`, `req0_k`  in  8 each  requester 0 operands.
- `req0_op`  in  1  requester 0 operation: 1 = add, 0 = multiply.
- `req1_valid`, `req1_ready`, `req1_i`, `req1_j`, `req1_k`, `req1_op`  same as requester 0, for requester 1.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  8  result.
- `out_src`  out  1  requester ID of the result.
- `busy`  out  1  FSM is not in IDLE.

## Operation
States: IDLE, DIFF, ADD, MUL0, MUL1, MUL2, OUT.

Arbitration (IDLE only):
- `grant0 = req0_valid & (!req1_valid | ptr==0)`.
- `grant1 = req1_valid & (!req0_valid | ptr==1)`.
- `reqN_ready = (state==IDLE) & grantN`. This is combinational from valid; exactly one ready at most.
- On accept: latch the operands, set `src = N`, set `ptr <= ~N`, go to DIFF.

DIFF:
- `d <= (j > i) ? j − i : i − j`, 8-bit unsigned magnitude.
- Next state is ADD if `op = 1`, else MUL0.

ADD: `acc <= d + k` (mod 256), then go to OUT.

Multiply operand split:
- `a = d[3:0]`, `b = d[7:4]`.
- `c = k[3:0]`, `e = k[7:4]`.

Multiply states:
- **MUL0:** `acc <= a*c` (8-bit).
  - Next is MUL1 if `b≠0 && c≠0`.
  - Else MUL2 if `a≠0 && e≠0`.
  - Else OUT.
- **MUL1:** `acc <= acc + {(b*c)[3:0], 4'h0}` (mod 256).
  - Next is MUL2 if `a≠0 && e≠0`, else OUT.
- **MUL2:** `acc <= acc + {(a*e)[3:0], 4'h0}` (mod 256), then go to OUT.
- Result equals `(d*k) mod 256`. The `b*e` term never contributes.

OUT:
- `out_valid = 1`, `out_data = acc`, `out_src = src`.
- Data and src are held stable until `out_ready`.
- On `out_valid & out_ready`, go to IDLE.

Other rules:
- `busy = (state != IDLE)`. No requests are accepted while busy.
- The input operands are don't-care except in the accept cycle.

## Timing
Reset (synchronous, takes effect at the next edge):
- State IDLE, `ptr = 0`; `acc`, `d`, `src` cleared.
- `out_valid = 0`, `out_data = 0`, `out_src = 0`, `busy = 0`.
- Both readys are 0 during the reset cycle.

Latency (accept edge T = edge where valid&ready):
- DIFF occupies cycle T+1.
- Add: ADD at T+2, `out_valid` from cycle T+3.
- Multiply: MUL0 at T+2, `out_valid` from T+3, T+4 or T+5 for 0, 1 or 2 additional partial-product steps.

Throughput:
- The earliest next accept is the cycle after the OUT handshake edge, i.e. one IDLE cycle minimum.
- Back-to-back add transactions are therefore spaced 4 cycles apart when `out_ready = 1`.

Boundary conditions:
- `i == j`: `d = 0`. Add returns `k`; multiply goes MUL0→OUT with result 0.
- Overflow wraps silently.
- Both requesters valid: `ptr` decides; the winner's ID is written to `src`; the loser keeps `valid` high and is served next.
- A single valid requester is granted regardless of `ptr`, and `ptr` still flips to the other ID.
- `out_ready` held low: the FSM stays in OUT indefinitely, and both readys stay 0.
- `rst` asserted in any state (including OUT with `out_valid` high): return to the reset values at the next edge. The in-flight transaction is dropped, with no output.

## Test plan
- **Add:** `req0` with `i=0x10, j=0x30, k=0x05, op=1`.
  - `req0_ready` high in IDLE.
  - `out_valid` at T+3 with `out_data=0x25`, `out_src=0`.
- **Multiply, zero-skip:** `req1` with `i=0x05, j=0x02, k=0x03, op=0`.
  - `d=0x03`; MUL1 and MUL2 are skipped.
  - `out_valid` at T+3 with `out_data=0x09`, `out_src=1`.
- **Multiply, full:** `i=0x20, j=0x07, k=0x13, op=0`.
  - `d=0x19`; all steps run.
  - `out_valid` at T+5 with `out_data=0xDB`.
- **Arbitration:** both requesters valid continuously after reset.
  - Grants go `req0`, `req1`, `req0`, …
  - `out_src` alternates 0, 1, 0; no request is starved.
- **Backpressure:** `out_ready=0` for 10 cycles during an add result.
  - `out_valid`, `out_data` and `out_src` stay stable.
  - `busy=1` and both readys stay 0 throughout.
  - The handshake completes on the first `out_ready=1`; the next accept is possible one cycle later.
- **Reset mid-operation:** assert `rst` while in MUL1.
  - Next cycle: IDLE, `out_valid=0`, `ptr=0`.
  - No result is emitted for the dropped transaction.
  - A subsequent `req0` add completes normally.

Source files
------------

// File: rtl/diffaddmul_sched.sv
// diffaddmul_sched
// Sequencing controller for a difference / add / multiply datapath.
// Two requesters hand in (i, j, k, op) through valid/ready handshakes, with
// round-robin arbitration. The controller forms d = |i - j|, then either
// adds k in one step (op = 1) or multiplies by k (op = 0). The multiply uses
// 4x4 partial products and skips steps whose partial product is zero.
// One transaction is in flight at a time. The 8-bit result and the
// requester ID leave through a valid/ready output port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid / reqN_ready  requester N handshake (N = 0, 1)
//   reqN_i, reqN_j, reqN_k   requester N operands, 8 bits each
//   reqN_op                  1 = add, 0 = multiply
//   out_valid / out_ready    result handshake
//   out_data, out_src        result (mod 256) and requester ID
//   busy                     controller is not idle
module diffaddmul_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_i,
  input  logic [7:0] req0_j,
  input  logic [7:0] req0_k,
  input  logic       req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_i,
  input  logic [7:0] req1_j,
  input  logic [7:0] req1_k,
  input  logic       req1_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_src,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, DIFF, ADD, MUL0, MUL1, MUL2, OUT} state_t;

  state_t     state, state_nxt;
  logic       ptr, src, op;
  logic [7:0] opi, opj, opk, d, acc;
  logic       grant0, grant1;
  logic       need_mul1, need_mul2;

  // Full 8-bit product of two nibbles.
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] p;
    p = {4'h0, x} * {4'h0, y};
    return p;
  endfunction

  // A cross term has weight 16, so only the low nibble of its product
  // survives modulo 256.
  function automatic logic [7:0] cross_term(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] p;
    p = mul4(x, y);
    return {p[3:0], 4'h0};
  endfunction

  // Arbitration is combinational from valid. It is gated by reset so that
  // neither requester sees ready during a reset cycle.
  assign grant0 = req0_valid & (~req1_valid | (ptr == 1'b0));
  assign grant1 = req1_valid & (~req0_valid | (ptr == 1'b1));
  assign req0_ready = (state == IDLE) & ~rst & grant0;
  assign req1_ready = (state == IDLE) & ~rst & grant1;

  // Operand nibbles: a = d[3:0], b = d[7:4], c = k[3:0], e = k[7:4].
  assign need_mul1 = (d[7:4] != 4'h0) && (opk[3:0] != 4'h0);
  assign need_mul2 = (d[3:0] != 4'h0) && (opk[7:4] != 4'h0);

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign out_data  = (state == OUT) ? acc : 8'h00;
  assign out_src   = (state == OUT) ? src : 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req0_ready || req1_ready) state_nxt = DIFF;
      DIFF: state_nxt = op ? ADD : MUL0;
      ADD:  state_nxt = OUT;
      MUL0: begin
        if (need_mul1)      state_nxt = MUL1;
        else if (need_mul2) state_nxt = MUL2;
        else                state_nxt = OUT;
      end
      MUL1: state_nxt = need_mul2 ? MUL2 : OUT;
      MUL2: state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      src   <= 1'b0;
      op    <= 1'b0;
      opi   <= 8'h00;
      opj   <= 8'h00;
      opk   <= 8'h00;
      d     <= 8'h00;
      acc   <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req0_ready) begin
            opi <= req0_i;
            opj <= req0_j;
            opk <= req0_k;
            op  <= req0_op;
            src <= 1'b0;
            ptr <= 1'b1;
          end else if (req1_ready) begin
            opi <= req1_i;
            opj <= req1_j;
            opk <= req1_k;
            op  <= req1_op;
            src <= 1'b1;
            ptr <= 1'b0;
          end
        end
        DIFF: d   <= (opj > opi) ? (opj - opi) : (opi - opj);
        ADD:  acc <= d + opk;
        MUL0: acc <= mul4(d[3:0], opk[3:0]);
        MUL1: acc <= acc + cross_term(d[7:4], opk[3:0]);
        MUL2: acc <= acc + cross_term(d[3:0], opk[7:4]);
        default: ;
      endcase
    end
  end

endmodule
